// File: rtl/fft_frame_arb_pkg.sv
// Shared constants for the fft frame arbiter: core widths, frame geometry
// helper and FSM state encodings.
package fft_frame_arb_pkg;

  localparam int TOTAL_STAGE = 8;
  localparam int REAL_WIDTH  = 16;
  localparam int IMGN_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic int frame_len(input int stage);
    return 1 << stage;
  endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// 1-bit tag FIFO remembering which channel owns each frame in flight in the core.
module fft_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     iclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge iclk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally; callers mask it with empty.
  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/fft_frame_arb.sv
// Round-robin frame arbiter in front of the shared fft core: feeds whole frames
// from ch0/ch1 into the core and tags the returning frames with their channel.
module fft_frame_arb
  import fft_frame_arb_pkg::*;
#(
  parameter int STAGE = TOTAL_STAGE,
  parameter int RW    = REAL_WIDTH,
  parameter int IW    = IMGN_WIDTH,
  parameter int GAP   = 2,
  parameter int MAXF  = 2
) (
  input  logic             iclk,
  input  logic             rst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [RW-1:0]    s0_real,
  input  logic [IW-1:0]    s0_imag,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [RW-1:0]    s1_real,
  input  logic [IW-1:0]    s1_imag,
  output logic [STAGE-1:0] c_iaddr,
  output logic [RW-1:0]    c_iReal,
  output logic [IW-1:0]    c_iImag,
  output logic             c_ien,
  input  logic [RW-1:0]    c_oReal,
  input  logic [IW-1:0]    c_oImag,
  input  logic [STAGE-1:0] c_oaddr,
  input  logic             c_oen,
  output logic             m_valid,
  output logic [RW-1:0]    m_real,
  output logic [IW-1:0]    m_imag,
  output logic [STAGE-1:0] m_addr,
  output logic             m_ch,
  output logic             m_last,
  output logic             busy,
  output logic             err_orphan
);

  logic [1:0]          state_reg;
  logic                gnt_reg;
  logic                rr_reg;
  logic [STAGE-1:0]    addr_reg;
  logic [3:0]          gap_cnt_reg;

  logic [1:0]          s_valid;
  logic [1:0]          s_ready;
  logic                hs;
  logic                grant;
  logic                grant_ch;
  logic                tag_push;
  logic                tag_pop;
  logic                tag_head;
  logic                tag_empty;
  logic                tag_full;
  logic [$clog2(MAXF):0] tag_count;

  assign s_valid = {s1_valid, s0_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign s_ready[gi] = (state_reg == ST_LOAD) && (gnt_reg == 1'(gi));
    end
  endgenerate

  assign s0_ready = s_ready[0];
  assign s1_ready = s_ready[1];
  assign hs       = |(s_valid & s_ready);

  // Grant looks at the registered FIFO fill, so a pop in the same cycle does not help.
  assign grant    = (|s_valid) & ~tag_full;
  assign grant_ch = (&s_valid) ? rr_reg : s_valid[1];
  assign tag_push = (state_reg == ST_IDLE) & grant;
  assign tag_pop  = c_oen & (&c_oaddr);

  fft_tag_fifo #(.DEPTH(MAXF)) u_tag_fifo (
    .iclk  (iclk),
    .rst_n (rst_n),
    .push  (tag_push),
    .din   (grant_ch),
    .pop   (tag_pop),
    .dout  (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= 1'b0;
      rr_reg      <= 1'b0;
      addr_reg    <= '0;
      gap_cnt_reg <= '0;
      c_ien       <= 1'b0;
      c_iaddr     <= '0;
      c_iReal     <= '0;
      c_iImag     <= '0;
    end else begin
      c_ien <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant) begin
            gnt_reg   <= grant_ch;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            c_ien    <= 1'b1;
            c_iaddr  <= addr_reg;
            c_iReal  <= gnt_reg ? s1_real : s0_real;
            c_iImag  <= gnt_reg ? s1_imag : s0_imag;
            addr_reg <= addr_reg + 1'b1;
            if (&addr_reg) begin
              rr_reg      <= ~gnt_reg;
              gap_cnt_reg <= '0;
              state_reg   <= (GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
          if (gap_cnt_reg == 4'(GAP - 1)) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_real     <= '0;
      m_imag     <= '0;
      m_addr     <= '0;
      m_ch       <= 1'b0;
      m_last     <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      m_valid    <= c_oen;
      m_real     <= c_oReal;
      m_imag     <= c_oImag;
      m_addr     <= c_oaddr;
      m_ch       <= tag_empty ? 1'b0 : tag_head;
      m_last     <= tag_pop;
      err_orphan <= err_orphan | (c_oen & tag_empty);
    end
  end

  assign busy = (state_reg != ST_IDLE) | (tag_count != '0);

endmodule

// File: tb/tb_fft_frame_arb.sv
// Directed-sequence bench with randomized sample data, checked against a
// frame-level model of grants, core writes and tagged core output.
module tb_fft_frame_arb;

  localparam int STAGE = 8;
  localparam int N     = 1 << STAGE;
  localparam int RW    = 16;
  localparam int IW    = 16;
  localparam int GAP   = 2;
  localparam int MAXF  = 2;

  logic             iclk;
  logic             rst_n;
  logic             s0_valid, s0_ready, s1_valid, s1_ready;
  logic [RW-1:0]    s0_real, s1_real;
  logic [IW-1:0]    s0_imag, s1_imag;
  logic [STAGE-1:0] c_iaddr;
  logic [RW-1:0]    c_iReal;
  logic [IW-1:0]    c_iImag;
  logic             c_ien;
  logic [RW-1:0]    c_oReal;
  logic [IW-1:0]    c_oImag;
  logic [STAGE-1:0] c_oaddr;
  logic             c_oen;
  logic             m_valid;
  logic [RW-1:0]    m_real;
  logic [IW-1:0]    m_imag;
  logic [STAGE-1:0] m_addr;
  logic             m_ch, m_last, busy, err_orphan;

  fft_frame_arb #(.STAGE(STAGE), .RW(RW), .IW(IW), .GAP(GAP), .MAXF(MAXF)) dut (
    .iclk(iclk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_real(s0_real), .s0_imag(s0_imag),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_real(s1_real), .s1_imag(s1_imag),
    .c_iaddr(c_iaddr), .c_iReal(c_iReal), .c_iImag(c_iImag), .c_ien(c_ien),
    .c_oReal(c_oReal), .c_oImag(c_oImag), .c_oaddr(c_oaddr), .c_oen(c_oen),
    .m_valid(m_valid), .m_real(m_real), .m_imag(m_imag), .m_addr(m_addr),
    .m_ch(m_ch), .m_last(m_last), .busy(busy), .err_orphan(err_orphan)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus knobs
  bit act0, act1, tog1, core_en, inj;

  // Reference model state
  bit          rr_m;
  int          exp_addr;
  bit          fr_ch;
  bit          pend;
  logic [7:0]  pend_addr;
  logic [15:0] pend_re, pend_im;
  int          frames_done;
  int          frames_core;
  int          oaddr_m;
  bit          tagq[$];
  bit          opend, o_ch, o_last;
  logic [7:0]  o_addr;
  logic [15:0] o_re, o_im;
  bit          err_m;
  logic [7:0]  last_iaddr;
  int          last_ien_cyc;
  int          ien_total;
  int          gaps[$];
  int          mlast_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr_m = 1'b0; exp_addr = 0; pend = 1'b0; frames_core = 0; oaddr_m = 0;
    tagq.delete(); err_m = 1'b0; last_iaddr = '0; opend = 1'b0;
  endtask

  // One clock: drive both sides, predict, advance, compare.
  task automatic step();
    bit hs0, hs1, exp_ch;
    s0_valid = act0;
    s1_valid = act1 && (!tog1 || (cyc % 2) == 0);
    s0_real = 16'($urandom); s0_imag = 16'($urandom);
    s1_real = 16'($urandom); s1_imag = 16'($urandom);
    c_oReal = 16'($urandom); c_oImag = 16'($urandom);
    if (inj) begin
      c_oen = 1'b1; c_oaddr = 8'd5;
    end else if (core_en && frames_core > 0) begin
      c_oen = 1'b1; c_oaddr = 8'(oaddr_m);
      oaddr_m++;
      if (oaddr_m == N) begin oaddr_m = 0; frames_core--; end
    end else begin
      c_oen = 1'b0; c_oaddr = '0;
    end

    chk("ready_exclusive", {31'd0, s0_ready & s1_ready}, 32'd0);
    hs0 = s0_valid && s0_ready;
    hs1 = s1_valid && s1_ready;
    pend = hs0 || hs1;
    if (pend) begin
      if (exp_addr == 0) begin
        exp_ch = (act0 && act1) ? rr_m : act1;
        chk("grant_ch", {31'd0, hs1}, {31'd0, exp_ch});
        fr_ch = exp_ch;
        tagq.push_back(exp_ch);
      end else begin
        chk("frame_ch", {31'd0, hs1}, {31'd0, fr_ch});
      end
      pend_addr = 8'(exp_addr);
      pend_re = hs1 ? s1_real : s0_real;
      pend_im = hs1 ? s1_imag : s0_imag;
      exp_addr++;
      if (exp_addr == N) begin
        exp_addr = 0; frames_done++; frames_core++; rr_m = ~fr_ch;
      end
    end

    opend  = c_oen;
    o_addr = c_oaddr; o_re = c_oReal; o_im = c_oImag;
    o_ch   = (tagq.size() != 0) ? tagq[0] : 1'b0;
    o_last = c_oen && (c_oaddr == 8'(N - 1));
    if (c_oen && tagq.size() == 0) err_m = 1'b1;
    if (o_last && tagq.size() != 0) tagq.delete(0);

    @(posedge iclk);
    #1;
    cyc++;
    chk("c_ien", {31'd0, c_ien}, {31'd0, pend});
    if (pend) begin
      chk("c_iaddr", {24'd0, c_iaddr}, {24'd0, pend_addr});
      chk("c_iReal", {16'd0, c_iReal}, {16'd0, pend_re});
      chk("c_iImag", {16'd0, c_iImag}, {16'd0, pend_im});
      if (pend_addr == 8'd0 && ien_total > 0) gaps.push_back(cyc - last_ien_cyc - 1);
      last_ien_cyc = cyc;
      ien_total++;
      last_iaddr = pend_addr;
    end else begin
      chk("c_iaddr_hold", {24'd0, c_iaddr}, {24'd0, last_iaddr});
    end
    chk("m_valid", {31'd0, m_valid}, {31'd0, opend});
    if (opend) begin
      chk("m_addr", {24'd0, m_addr}, {24'd0, o_addr});
      chk("m_real", {16'd0, m_real}, {16'd0, o_re});
      chk("m_imag", {16'd0, m_imag}, {16'd0, o_im});
      chk("m_ch", {31'd0, m_ch}, {31'd0, o_ch});
      if (o_last) mlast_cnt++;
    end
    chk("m_last", {31'd0, m_last}, {31'd0, o_last});
    chk("err_orphan", {31'd0, err_orphan}, {31'd0, err_m});
  endtask

  task automatic run_frames(input int n, input int budget);
    int target;
    target = frames_done + n;
    for (int i = 0; i < budget && frames_done < target; i++) step();
    chk("frames_in_budget", frames_done, target);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (tagq.size() != 0 || frames_core != 0); i++) step();
    chk("drain_in_budget", tagq.size(), 0);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {30'd0, s0_ready, s1_ready}, 32'd0);
    chk({tag, "_cin"}, {7'd0, c_ien, c_iaddr, c_iReal}, 32'd0);
    chk({tag, "_cimag"}, {16'd0, c_iImag}, 32'd0);
    chk({tag, "_mdata"}, {m_real, m_imag}, 32'd0);
    chk({tag, "_mctl"}, {20'd0, m_valid, m_addr, m_ch, m_last, busy, err_orphan}, 32'd0);
  endtask

  initial begin
    int ien_start, ml_start;
    bit seen;
    rst_n = 1'b0;
    act0 = 0; act1 = 0; tog1 = 0; core_en = 1; inj = 0;
    s0_valid = 0; s1_valid = 0; s0_real = '0; s0_imag = '0; s1_real = '0; s1_imag = '0;
    c_oen = 0; c_oaddr = '0; c_oReal = '0; c_oImag = '0;
    frames_done = 0; ien_total = 0; last_ien_cyc = 0; mlast_cnt = 0; fr_ch = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge iclk);
    rst_n = 1'b1;
    @(posedge iclk);
    #1;

    // 1: single ch0 frame with loopback output
    act0 = 1;
    run_frames(1, 400);
    act0 = 0;
    drain(600);
    chk("t1_ien_total", ien_total, N);
    chk("t1_mlast_cnt", mlast_cnt, 1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: both channels always valid; alternating grants, fixed spacing
    act0 = 1; act1 = 1;
    run_frames(3, 1300);
    act0 = 0; act1 = 0;
    chk("t2_gap_count", {31'd0, gaps.size() >= 3}, 32'd1);
    if (gaps.size() >= 3) begin
      chk("t2_gap_a", gaps[gaps.size() - 1], GAP + 1);
      chk("t2_gap_b", gaps[gaps.size() - 2], GAP + 1);
    end
    drain(800);

    // 3: ch1 valid on alternate cycles
    act1 = 1; tog1 = 1;
    ien_start = ien_total;
    run_frames(1, 800);
    act1 = 0; tog1 = 0;
    chk("t3_writes", ien_total - ien_start, N);
    drain(600);

    // 4: core output withheld until MAXF frames are in flight
    core_en = 0; act0 = 1;
    run_frames(MAXF, 900);
    for (int i = 0; i < 20; i++) step();
    chk("t4_blocked_frames", tagq.size(), MAXF);
    chk("t4_ready_low", {31'd0, s0_ready}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    core_en = 1;
    ml_start = mlast_cnt;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (o_last) seen = 1;
    end
    chk("t4_mlast_seen", mlast_cnt - ml_start, 1);
    chk("t4_no_grant_same_cycle", {31'd0, s0_ready}, 32'd0);
    step();
    chk("t4_grant_next_cycle", {31'd0, s0_ready}, 32'd1);
    run_frames(1, 400);
    act0 = 0;
    drain(1200);

    // 5: orphan core output, then a normal frame
    inj = 1;
    step();
    inj = 0;
    step();
    chk("t5_orphan_set", {31'd0, err_orphan}, 32'd1);
    act0 = 1;
    run_frames(1, 400);
    act0 = 0;
    drain(600);
    chk("t5_orphan_sticky", {31'd0, err_orphan}, 32'd1);

    // 6: asynchronous reset in the middle of a frame
    act0 = 1;
    for (int i = 0; i < 400 && exp_addr != 100; i++) step();
    chk("t6_reach_addr", exp_addr, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    act0 = 0;
    s0_valid = 0; s1_valid = 0; c_oen = 0;
    model_reset();
    @(posedge iclk);
    @(negedge iclk);
    rst_n = 1'b1;
    @(posedge iclk);
    #1;
    act0 = 1; act1 = 1;
    run_frames(1, 400);
    act0 = 0; act1 = 0;
    drain(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_arb.md
Name: fft_frame_arb

Overview:
- Frame-level arbiter and sequencer in front of the shared fft/ifft core.
- Accepts sample streams from two requesters (ch0, ch1) over valid/ready.
- Grants the core one whole frame at a time, round-robin, and drives the core's iaddr/iReal/iImag/ien.
- Tags returning core output (oen/oaddr/oReal/oImag) with the originating channel and marks frame boundaries.

Parameters:
- STAGE, 8, log2 of frame length N (N = 1<<STAGE); matches core TOTAL_STAGE.
- RW, 16, real sample width; matches core REAL_WIDTH.
- IW, 16, imaginary sample width; matches core IMGN_WIDTH.
- GAP, 2, idle cycles with core ien low between consecutive input frames (1..15).
- MAXF, 2, maximum frames in flight in the core; tag FIFO depth (power of 2).

Ports:
- iclk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s0_valid / s0_ready  in / out  1 / 1  ch0 sample handshake
- s0_real / s0_imag  in  RW / IW  ch0 sample
- s1_valid / s1_ready  in / out  1 / 1  ch1 sample handshake
- s1_real / s1_imag  in  RW / IW  ch1 sample
- c_iaddr  out  STAGE  core input address
- c_iReal / c_iImag  out  RW / IW  core input sample
- c_ien  out  1  core input write enable
- c_oReal / c_oImag  in  RW / IW  core output sample
- c_oaddr  in  STAGE  core output address
- c_oen  in  1  core output valid
- m_valid  out  1  output sample valid
- m_real / m_imag  out  RW / IW  output sample
- m_addr  out  STAGE  output bin index
- m_ch  out  1  channel owning the output frame
- m_last  out  1  high with the final sample (m_addr = N-1) of a frame
- busy  out  1  FSM not IDLE, or any frame in flight
- err_orphan  out  1  sticky; core output seen with tag FIFO empty

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; rr pointer=ch0; addr counter=0; gap counter=0; tag FIFO empty.
  - All outputs 0: s*_ready, c_ien, c_iaddr, c_iReal, c_iImag, m_*, busy, err_orphan.
  - Reset mid-frame abandons the frame with no partial-frame recovery.
- FSM states: IDLE, LOAD, GAP.
- IDLE: grant when some s*_valid=1 and tag FIFO count < MAXF.
  - Both valid: pick the rr-preferred channel. One valid: pick it.
  - On grant: latch gnt; push gnt into tag FIFO; go to LOAD. Grant decision costs one cycle; no ready asserted in IDLE.
- LOAD: s<gnt>_ready=1; the other channel's ready=0.
  - Each handshake (valid&ready) registers sample to c_iReal/c_iImag, c_iaddr=addr, c_ien=1 the next cycle; addr++.
  - No handshake: c_ien=0 next cycle, c_iaddr holds. Core writes only when ien=1, so stalls are legal.
  - Handshake at addr=N-1: addr wraps to 0; rr pointer = other channel; go to GAP (or IDLE if GAP=0).
- GAP: count GAP cycles with c_ien=0, then IDLE.
- Input latency: handshake to c_ien = 1 cycle. Exactly N c_ien pulses per frame, addresses 0..N-1 in order.
- Output path: registered, 1-cycle latency.
  - m_valid=c_oen; m_real/m_imag/m_addr = c_oReal/c_oImag/c_oaddr; m_ch = tag FIFO head.
  - m_last = c_oen & (c_oaddr == N-1); pops the tag FIFO.
  - No backpressure on m_*; the consumer must always accept.
- Simultaneous push (grant) and pop (m_last) in one cycle: count unchanged, both take effect. Full FIFO with pop that cycle still blocks the grant (grant uses registered count).
- c_oen with FIFO empty: err_orphan set (sticky until reset); m_ch=0; sample still forwarded.
- busy = (FSM != IDLE) | (count != 0).

Decomposition:
- Shared package/include alongside fft_inc.h: N derived from STAGE, FSM state encodings, RW/IW defaults tied to REAL_WIDTH/IMGN_WIDTH.
- One sub-module: fft_tag_fifo, a synchronous 1-bit-wide FIFO of depth MAXF with push/pop/count/empty/full.

Test Plan:
- Single ch0 frame, N=256, s0_valid held high -> c_ien high 256 consecutive cycles, c_iaddr 0..255, one cycle after each handshake. Core loopback output -> 256 m_valid, m_ch=0, m_last only at m_addr=255.
- Both channels valid continuously -> grants alternate ch0, ch1, ch0. Exactly GAP=2 idle ien cycles plus 1 IDLE cycle between frames. m_ch sequence 0,1,0 matches input order.
- ch1 valid toggling every other cycle -> c_ien pulses only on handshakes. c_iaddr holds during stalls; still 256 writes with no skipped or repeated address.
- Core output withheld: grant frames until count=MAXF=2 -> third frame not granted (s*_ready=0, busy=1). Emit m_last for frame 0 -> next cycle grant proceeds.
- Inject c_oen with no frame granted -> err_orphan=1 and stays 1 through later normal frames until rst_n pulse.
- Assert rst_n=0 asynchronously at addr=100 in LOAD -> all outputs 0 immediately. After release, a new frame starts at c_iaddr=0 with the rr pointer at ch0.
